// File: rtl/phys_freelist.sv
// phys_freelist: physical-register free list for the R10K-style rename path.
//
// Holds the free physical tags as a bitmap and offers up to WIDTH tags per
// cycle to dispatch, lowest index first. Retire returns tags through
// free_mask. On a mispredict the bitmap is reloaded wholesale from
// restore_mask. Tag 0 (zero register) is never offered and never freed.
//
// Parameters:
//   NUM_PHYS  physical tag count (PHYS_REG_SZ_R10K, 64)
//   NUM_ARCH  tags 0..NUM_ARCH-1 are busy out of reset (ARCH_REG_SZ, 32)
//   WIDTH     allocation lanes per cycle (N, 3)
//
// Ports:
//   clock, reset  clock; synchronous active-high reset
//   alloc_req     per-lane allocation request
//   alloc_tags    per-lane offered tag (combinational from current state)
//   alloc_valid   per-lane offer is real (combinational)
//   free_mask     tags released by retire this cycle
//   mispredict    load restore_mask this cycle
//   restore_mask  architectural free set from retire
//   free_count    registered popcount of the bitmap
//   double_free   sticky flag: a free hit an already-free tag
//
// Build option:
//   FREELIST_FREE_BYPASS_EN  when defined, this cycle's free_mask tags are
//                            offerable in the same cycle (retire->dispatch
//                            combinational path).
module phys_freelist #(
    parameter int unsigned NUM_PHYS = 64,
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned WIDTH    = 3
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [WIDTH-1:0]                            alloc_req,
    output logic [WIDTH-1:0][$clog2(NUM_PHYS)-1:0]      alloc_tags,
    output logic [WIDTH-1:0]                            alloc_valid,
    input  logic [NUM_PHYS-1:0]                         free_mask,
    input  logic                                        mispredict,
    input  logic [NUM_PHYS-1:0]                         restore_mask,
    output logic [$clog2(NUM_PHYS+1)-1:0]               free_count,
    output logic                                        double_free
);

    localparam int unsigned TAG_W = $clog2(NUM_PHYS);
    localparam int unsigned CNT_W = $clog2(NUM_PHYS + 1);
    localparam logic [NUM_PHYS-1:0] ALL_ONES    = '1;
    localparam logic [NUM_PHYS-1:0] RESET_AVAIL = ALL_ONES << NUM_ARCH;

    logic [NUM_PHYS-1:0] avail;
    logic [NUM_PHYS-1:0] avail_next;
    logic [NUM_PHYS-1:0] free_eff;
    logic [NUM_PHYS-1:0] eligible;
    logic [NUM_PHYS-1:0] granted;
    logic                double_free_next;
    logic [CNT_W-1:0]    rank;

    // Retire can never free the zero register.
    always_comb begin
        free_eff    = free_mask;
        free_eff[0] = 1'b0;
`ifdef FREELIST_FREE_BYPASS_EN
        eligible    = avail | free_eff;
`else
        eligible    = avail;
`endif
    end

    // Offer: lane i gets the eligible tag whose rank (count of eligible tags
    // below it) equals i. Lanes beyond the eligible population stay invalid.
    always_comb begin
        alloc_tags  = '0;
        alloc_valid = '0;
        rank        = '0;
        for (int b = 0; b < int'(NUM_PHYS); b++) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (eligible[b] && (rank == CNT_W'(i))) begin
                    alloc_tags[i]  = TAG_W'(b);
                    alloc_valid[i] = 1'b1;
                end
            end
            rank = rank + CNT_W'(eligible[b]);
        end
    end

    // Grant is fixed by lane index: an unrequested lane leaves its tag free.
    always_comb begin
        granted = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (alloc_req[i] && alloc_valid[i]) begin
                granted[alloc_tags[i]] = 1'b1;
            end
        end
    end

    // Next bitmap; a mispredict overrides frees and grants, and retire's
    // restore mask already accounts for this cycle's frees.
    always_comb begin
        if (mispredict) begin
            avail_next = restore_mask;
        end else begin
            avail_next = (avail | free_eff) & ~granted;
        end
        avail_next[0]    = 1'b0;
        double_free_next = double_free | (!mispredict && (|(free_eff & avail)));
    end

    // State registers; free_count is a fresh popcount, never incremented.
    always_ff @(posedge clock) begin
        if (reset) begin
            avail       <= RESET_AVAIL;
            free_count  <= CNT_W'(NUM_PHYS - NUM_ARCH);
            double_free <= 1'b0;
        end else begin
            avail       <= avail_next;
            free_count  <= CNT_W'($countones(avail_next));
            double_free <= double_free_next;
        end
    end

endmodule

// File: tb/tb_phys_freelist.sv
// tb_phys_freelist: self-checking bench for phys_freelist (default params).
module tb_phys_freelist;

    localparam int unsigned NP = 64;
    localparam int unsigned NA = 32;
    localparam int unsigned W  = 3;
    localparam int unsigned TW = 6;
    localparam int unsigned CW = 7;
    localparam logic [NP-1:0] ONES = '1;
    localparam logic [NP-1:0] NOT0 = ~NP'(1);

    logic                    clock = 1'b0;
    logic                    reset;
    logic [W-1:0]            alloc_req;
    logic [W-1:0][TW-1:0]    alloc_tags;
    logic [W-1:0]            alloc_valid;
    logic [NP-1:0]           free_mask;
    logic                    mispredict;
    logic [NP-1:0]           restore_mask;
    logic [CW-1:0]           free_count;
    logic                    double_free;

    always #5 clock = ~clock;

    phys_freelist #(.NUM_PHYS(NP), .NUM_ARCH(NA), .WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_tags   (alloc_tags),
        .alloc_valid  (alloc_valid),
        .free_mask    (free_mask),
        .mispredict   (mispredict),
        .restore_mask (restore_mask),
        .free_count   (free_count),
        .double_free  (double_free)
    );

    typedef struct {
        logic [CW-1:0] cnt;
        logic          df;
    } exp_t;

    exp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [NP-1:0] m_avail;
    logic          m_df;
    bit            m_known = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference offer: walk forward to the next set bit for each lane.
    task automatic model_offer(input logic [NP-1:0] elig,
                               output logic [W-1:0][TW-1:0] t,
                               output logic [W-1:0] v);
        int pos;
        pos = 0;
        t   = '0;
        v   = '0;
        for (int i = 0; i < int'(W); i++) begin
            while (pos < int'(NP) && !elig[pos]) pos++;
            if (pos < int'(NP)) begin
                t[i] = TW'(pos);
                v[i] = 1'b1;
                pos++;
            end
        end
    endtask

    // One clock: drive, check the combinational offer, predict, then compare.
    task automatic cycle(input logic rst, input logic [W-1:0] req,
                         input logic [NP-1:0] fm, input logic mp,
                         input logic [NP-1:0] rm);
        logic [NP-1:0]        elig;
        logic [NP-1:0]        fmc;
        logic [NP-1:0]        gnt;
        logic [W-1:0][TW-1:0] et;
        logic [W-1:0]         ev;
        exp_t                 e;
        reset        = rst;
        alloc_req    = req;
        free_mask    = fm;
        mispredict   = mp;
        restore_mask = rm;
        #1;
        fmc  = fm & NOT0;
        elig = m_avail;
`ifdef FREELIST_FREE_BYPASS_EN
        elig = elig | fmc;
`endif
        model_offer(elig, et, ev);
        if (m_known && !rst) begin
            for (int i = 0; i < int'(W); i++) begin
                check($sformatf("tag%0d", i), 64'(alloc_tags[i]), 64'(et[i]));
            end
            check("valid", 64'(alloc_valid), 64'(ev));
        end
        gnt = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (req[i] && ev[i]) gnt[et[i]] = 1'b1;
        end
        if (rst) begin
            m_avail = ONES << NA;
            m_df    = 1'b0;
            m_known = 1'b1;
        end else if (mp) begin
            m_avail = rm & NOT0;
        end else begin
            m_df    = m_df | (|(fmc & m_avail));
            m_avail = (m_avail | fmc) & ~gnt;
        end
        e.cnt = CW'($countones(m_avail));
        e.df  = m_df;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        if (m_known) begin
            check("free_count", 64'(free_count), 64'(e.cnt));
            check("double_free", 64'(double_free), 64'(e.df));
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic chk_offer(input string tag, input int t0, input int t1, input int t2);
        check({tag, "_t0"}, 64'(alloc_tags[0]), 64'(t0));
        check({tag, "_t1"}, 64'(alloc_tags[1]), 64'(t1));
        check({tag, "_t2"}, 64'(alloc_tags[2]), 64'(t2));
        check({tag, "_v"},  64'(alloc_valid), 64'(3'b111));
    endtask

    logic [NP-1:0] rm_a;
    logic [NP-1:0] bit_mask;

    initial begin
        reset = 1'b1; alloc_req = '0; free_mask = '0; mispredict = 1'b0; restore_mask = '0;
        @(posedge clock);
        #1;
        cycle(1'b1, '0, '0, 1'b0, '0);
        cycle(1'b1, '0, '0, 1'b0, '0);
        #1;
        check("rst_count", 64'(free_count), 64'd32);
        check("rst_df", 64'(double_free), 64'd0);
        chk_offer("rst", 32, 33, 34);

        // Allocate three, then free tag 33.
        cycle(1'b0, 3'b111, '0, 1'b0, '0);
        check("alloc_count", 64'(free_count), 64'd29);
        chk_offer("alloc", 35, 36, 37);
        bit_mask = NP'(1) << 33;
        cycle(1'b0, '0, bit_mask, 1'b0, '0);
        check("free33_count", 64'(free_count), 64'd30);
        chk_offer("free33", 33, 35, 36);

        // Drain to empty, then a dropped request.
        for (int k = 0; k < 20 && alloc_valid != '0; k++) cycle(1'b0, 3'b111, '0, 1'b0, '0);
        check("empty_count", 64'(free_count), 64'd0);
        check("empty_valid", 64'(alloc_valid), 64'd0);
        cycle(1'b0, 3'b111, '0, 1'b0, '0);
        check("empty_hold", 64'(free_count), 64'd0);

        // Restore upper half.
        cycle(1'b0, '0, '0, 1'b1, ONES << 32);
        check("restore_count", 64'(free_count), 64'd32);
        chk_offer("restore", 32, 33, 34);

        // Mispredict with grants and a free; bit 0 of restore must be dropped.
        rm_a = 64'hF0F4_0000_1234_5671;
        cycle(1'b0, 3'b111, NP'(1) << 40, 1'b1, rm_a);
        check("mp_count", 64'(free_count), 64'($countones(rm_a & NOT0)));
        chk_offer("mp", 4, 5, 6);

        // Free tag 0: ignored. Free tag 50 (already free): sticky error.
        cycle(1'b0, '0, NP'(1), 1'b0, '0);
        check("free0_count", 64'(free_count), 64'($countones(rm_a & NOT0)));
        check("free0_df", 64'(double_free), 64'd0);
        cycle(1'b0, '0, NP'(1) << 50, 1'b0, '0);
        check("df_set", 64'(double_free), 64'd1);
        idle();
        idle();
        check("df_sticky", 64'(double_free), 64'd1);

        // Random traffic against the model.
        for (int k = 0; k < 60; k++) begin
            logic [NP-1:0] fm;
            logic          mp;
            int            t;
            fm = '0;
            t  = $urandom_range(1, int'(NP) - 1);
            if ($urandom_range(0, 2) == 0 && !m_avail[t]) fm[t] = 1'b1;
            mp = ($urandom_range(0, 9) == 0);
            cycle(1'b0, W'($urandom_range(0, 7)), fm, mp, {$urandom, $urandom});
        end
        check("df_still", 64'(double_free), 64'd1);

        // Reset beats mispredict, frees and grants.
        cycle(1'b1, 3'b111, NP'(1) << 5, 1'b1, {$urandom, $urandom});
        check("rst2_count", 64'(free_count), 64'd32);
        check("rst2_df", 64'(double_free), 64'd0);
        idle();
        chk_offer("rst2", 32, 33, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/phys_freelist.md
# phys_freelist

Physical-register free list for the R10K-style rename datapath. Tracks the set of free physical tags as a bitmap and hands out up to N tags per cycle to dispatch, lowest index first. Returns tags on the retire stage's per-cycle `free_mask` and reloads wholesale from retire's `freelist_restore_mask` on a mispredict.

## Interface
Parameters:
- `NUM_PHYS`, default `PHYS_REG_SZ_R10K` (64): physical tag count.
- `NUM_ARCH`, default `ARCH_REG_SZ` (32): tags 0..NUM_ARCH-1 are busy out of reset.
- `WIDTH`, default `N` (3): allocation lanes per cycle.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `alloc_req` in WIDTH: lane i wants a tag this cycle.
- `alloc_tags` out WIDTH x PHYS_TAG: lane i offered tag, combinational from current state.
- `alloc_valid` out WIDTH: lane i offer is real; equals `free_count > i`.
- `free_mask` in NUM_PHYS: tags released by retire this cycle.
- `mispredict` in 1: load restore mask this cycle.
- `restore_mask` in NUM_PHYS: architectural free set, from retire.
- `free_count` out $clog2(NUM_PHYS+1): registered popcount of bitmap.
- `double_free` out 1: sticky error flag.

## Operation
- State: `avail[NUM_PHYS]` (1 = free), `free_count` register, `double_free` register.
- Offer: `alloc_tags[i]` = (i+1)-th lowest set bit of the eligible set; eligible = `avail` (plus `free_mask` when bypass is compiled in). Lanes without a tag: `alloc_valid[i]`=0, `alloc_tags[i]`=0.
- Grant: lane i consumes its tag iff `alloc_req[i] && alloc_valid[i]`. Lane-to-tag mapping is fixed by lane index, not by request pattern; req=3'b101 consumes the 1st and 3rd offered tags, and the 2nd stays free.
- Normal next state: `avail_next = (avail | free_mask) & ~granted`, with bit 0 forced to 0.
- Mispredict: `avail_next = restore_mask` with bit 0 forced to 0. Grants and `free_mask` are ignored that cycle. Retire's restore mask already includes that cycle's frees.
- `free_count` is always popcount(`avail_next`), registered. It is never incrementally adjusted.
- Tag 0 (zero reg) is never offered and never freed. `free_mask[0]` is ignored.
- `double_free` sets when any bit of `free_mask & avail` is set on a non-mispredict cycle. It clears only on reset.

## Timing
- Reset values: `avail` = bits NUM_ARCH..NUM_PHYS-1 set, others clear; `free_count` = NUM_PHYS-NUM_ARCH (32); `double_free` = 0.
- Offer to grant is zero-latency, same cycle. Consumed tags disappear from the offer next cycle.
- Freed tags become offerable the cycle after `free_mask` asserts (zero cycles with bypass).
- Restored state is visible the cycle after `mispredict`.
- Empty: all `alloc_valid` = 0, and requests are dropped with no state change. Dispatch must stall on `!alloc_valid`.
- Reset asserted mid-operation wins over mispredict, frees and grants.

## Configuration
- `FREELIST_FREE_BYPASS_EN`
  - Defined: tags in this cycle's `free_mask` are eligible for this cycle's offer, and `alloc_valid[i]` uses popcount(`avail | free_mask`). This adds a combinational path from retire to dispatch.
  - Undefined: offer uses registered `avail` only.
  - Mispredict behaviour is identical in both builds.

## Test plan
- Reset, no activity -> `free_count`=32, `alloc_tags`={32,33,34}, `alloc_valid`=3'b111, `double_free`=0.
- Request 3'b111 for one cycle -> next cycle `free_count`=29 and offer {35,36,37}.
- After that allocation, `free_mask` bit 33 for one cycle -> next cycle lane 0 offers 33 and `free_count`=30. With bypass, 33 is offered in the same cycle.
- Allocate continuously until empty -> `alloc_valid`=0 once `free_count`=0. A further request leaves state unchanged. Then `mispredict` with restore_mask bits 32..63 -> next cycle `free_count`=32 and offer {32,33,34}.
- `mispredict` together with `alloc_req`=3'b111 and `free_mask` bit 40 -> state equals `restore_mask` exactly, and no grant is consumed.
- `free_mask` bit 50 while 50 is already free -> `double_free`=1 next cycle and stays 1 until reset. `free_mask` bit 0 -> no effect.
